// File: rtl/fiapp_obs_checker.sv
// Purpose: watches the fiapp register stage (o2 == o1 delayed, o3 == !o1 delayed), counts toggles/mismatches, queues timestamped mismatch events.
// Latency: counters/fault update on the sampling edge; an event is visible at the FWFT head the cycle after its mismatch.
// Backpressure: ev_valid/ev_ready drain; a push into a full FIFO with no pop is dropped and flagged by sticky ev_dropped.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   start, stop          arm / disarm pulses (stop wins over start and mismatch)
//   i1, i2, i3           observed o1/o2/o3 of the fiapp stage
//   state                0 IDLE, 1 ARM, 2 RUN, 3 FAULT
//   toggle_cnt, err_cnt  saturating i1-toggle and mismatch-cycle counts (RUN only)
//   fault                sticky mismatch flag since last start
//   ev_valid/ev_ready    event handshake; ev_ts/ev_code describe the head event
//   ev_dropped           sticky: an event was lost to a full FIFO
module fiapp_obs_checker #(
    parameter int CNT_W       = 16,
    parameter int TS_W        = 32,
    parameter int FIFO_DEPTH  = 4,
    parameter int STOP_ON_ERR = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             i1,
    input  logic             i2,
    input  logic             i3,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] toggle_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             fault,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [TS_W-1:0]  ev_ts,
    output logic [1:0]       ev_code,
    output logic             ev_dropped
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [TS_W-1:0]  TS_ONE  = {{(TS_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [AW:0]      PTR_ONE = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, RUN = 2'd2, FAULT = 2'd3} state_t;

    typedef struct packed {
        logic [TS_W-1:0] ts;
        logic [1:0]      code;
    } ev_t;

    state_t          cur, nxt;
    logic [TS_W-1:0] ts;
    logic            prev_i1;
    logic [1:0]      code;
    logic            run, start_acc, mism;

    ev_t             mem [FIFO_DEPTH];
    logic [AW:0]     rd_ptr, wr_ptr;
    logic            empty, full, pop, push_ok;

    // Expected: i2 == prev_i1 and i3 == !prev_i1.
    assign code = {(i3 != ~prev_i1), (i2 != prev_i1)};
    assign mism = run && (code != 2'b00);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) cur <= IDLE;
        else       cur <= nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        nxt = cur;
        case (cur)
            IDLE:  if (start && !stop) nxt = ARM;
            // ARM gives one history cycle: fiapp's o3 resets to 0, not !o1.
            ARM:   nxt = stop ? IDLE : RUN;
            RUN:   if (stop)                           nxt = IDLE;
                   else if (mism && STOP_ON_ERR != 0)  nxt = FAULT;
            FAULT: if (stop) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        run       = 1'b0;
        start_acc = 1'b0;
        state     = cur;
        if (cur == RUN)                     run       = 1'b1;
        if (cur == IDLE && start && !stop)  start_acc = 1'b1;
    end

    // ---------------- timestamp and history ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            ts      <= '0;
            prev_i1 <= 1'b0;
        end else begin
            ts      <= ts + TS_ONE;
            prev_i1 <= i1;
        end
    end

    // ---------------- event FIFO (first-word-fall-through) ----------------
    assign empty    = (rd_ptr == wr_ptr);
    assign full     = (rd_ptr[AW] != wr_ptr[AW]) && (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]);
    assign ev_valid = !empty;
    // A start flush wins over a pop in the same cycle; pushes never coincide with it (IDLE).
    assign pop      = ev_valid && ev_ready && !start_acc;
    // Full plus simultaneous pop frees the slot being written this edge.
    assign push_ok  = mism && (!full || pop);

    // Head is gated so stale storage never shows while the FIFO is empty.
    assign ev_ts   = ev_valid ? mem[rd_ptr[AW-1:0]].ts   : '0;
    assign ev_code = ev_valid ? mem[rd_ptr[AW-1:0]].code : 2'b00;

    always_ff @(posedge clk) begin
        if (reset || start_acc) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push_ok) mem[wr_ptr[AW-1:0]] <= '{ts: ts, code: code};
    end

    // ---------------- counters and sticky flags ----------------
    always_ff @(posedge clk) begin
        if (reset || start_acc) begin
            toggle_cnt <= '0;
            err_cnt    <= '0;
            fault      <= 1'b0;
            ev_dropped <= 1'b0;
        end else begin
            if (mism) begin
                if (err_cnt != '1) err_cnt <= err_cnt + CNT_ONE;
                fault <= 1'b1;
                if (!push_ok) ev_dropped <= 1'b1;
            end
            if (run && (i1 != prev_i1) && (toggle_cnt != '1))
                toggle_cnt <= toggle_cnt + CNT_ONE;
        end
    end
endmodule

// File: tb/tb_fiapp_obs_checker.sv
// Purpose: directed self-checking bench for fiapp_obs_checker (three parameterisations share stimulus).
// Latency: inputs change #1 after posedge, outputs sampled at the same point.
// Backpressure: each instance has its own ev_ready so queues can be held or drained independently.
module tb_fiapp_obs_checker;
    logic clk, reset, start, stop, i1, i2, i3;
    logic rdy, rdy_s, rdy_w;

    // main instance: defaults
    logic [1:0]  st;   logic [15:0] tog, err; logic flt, ev_v, ev_d; logic [31:0] ev_t; logic [1:0] ev_c;
    // stop-on-error instance, 4-bit timestamp
    logic [1:0]  st_s; logic [15:0] tog_s, err_s; logic flt_s, v_s, d_s; logic [3:0] t_s; logic [1:0] c_s;
    // narrow instance: 3-bit counters, 4-bit timestamp
    logic [1:0]  st_w; logic [2:0] tog_w, err_w; logic flt_w, v_w, d_w; logic [3:0] t_w; logic [1:0] c_w;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_ts = 0;
    logic        b_prev = 1'b0;

    fiapp_obs_checker dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .i1(i1), .i2(i2), .i3(i3),
        .state(st), .toggle_cnt(tog), .err_cnt(err), .fault(flt), .ev_valid(ev_v),
        .ev_ready(rdy), .ev_ts(ev_t), .ev_code(ev_c), .ev_dropped(ev_d));

    fiapp_obs_checker #(.TS_W(4), .STOP_ON_ERR(1)) dut_s (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .i1(i1), .i2(i2), .i3(i3),
        .state(st_s), .toggle_cnt(tog_s), .err_cnt(err_s), .fault(flt_s), .ev_valid(v_s),
        .ev_ready(rdy_s), .ev_ts(t_s), .ev_code(c_s), .ev_dropped(d_s));

    fiapp_obs_checker #(.CNT_W(3), .TS_W(4)) dut_w (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .i1(i1), .i2(i2), .i3(i3),
        .state(st_w), .toggle_cnt(tog_w), .err_cnt(err_w), .fault(flt_w), .ev_valid(v_w),
        .ev_ready(rdy_w), .ev_ts(t_w), .ev_code(c_w), .ev_dropped(d_w));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: track the timestamp and the i1 history the DUT should hold.
    task automatic step();
        @(posedge clk);
        exp_ts = reset ? 32'd0 : exp_ts + 32'd1;
        b_prev = reset ? 1'b0 : i1;
        #1;
    endtask

    // Well-behaved fiapp outputs for a chosen i1.
    task automatic good(input logic v);
        i1 = v; i2 = b_prev; i3 = ~b_prev;
    endtask

    // Hold i1 and corrupt i2 (c[0]) and/or i3 (c[1]).
    task automatic bad(input logic [1:0] c);
        i1 = b_prev;
        i2 = c[0] ? ~b_prev : b_prev;
        i3 = c[1] ? b_prev : ~b_prev;
    endtask

    initial begin
        logic [31:0] tq [0:6];
        logic [1:0]  cq [0:6];
        int          ord [0:2];
        logic [31:0] t4, t5, t6;
        logic        saw_v;
        int          n;

        reset = 1'b1; start = 1'b0; stop = 1'b0;
        rdy = 1'b0; rdy_s = 1'b0; rdy_w = 1'b0;
        good(1'b0);
        step(); step();
        chk("rst_state", st, 0);   chk("rst_tog", tog, 0);   chk("rst_err", err, 0);
        chk("rst_fault", flt, 0);  chk("rst_valid", ev_v, 0); chk("rst_ts", ev_t, 0);
        chk("rst_code", ev_c, 0);  chk("rst_drop", ev_d, 0);
        reset = 1'b0;

        // ---- well-behaved stream, i1 toggling every cycle ----
        start = 1'b1; good(1'b0); step(); start = 1'b0;
        chk("t1_arm", st, 1);
        saw_v = 1'b0;
        for (int k = 0; k < 20; k++) begin
            good(~b_prev); step();
            if (ev_v) saw_v = 1'b1;
        end
        chk("t1_state", st, 2); chk("t1_err", err, 0); chk("t1_fault", flt, 0);
        chk("t1_tog", tog, 19); chk("t1_never_valid", saw_v, 0);

        // ---- single i2 mismatch at ts 0x30 ----
        n = 0;
        while (exp_ts != 32'h30 && n < 200) begin good(b_prev); step(); n++; end
        chk("t2_reach_ts", exp_ts, 32'h30);
        bad(2'b01); step();
        chk("t2_err", err, 1); chk("t2_fault", flt, 1); chk("t2_valid", ev_v, 1);
        chk("t2_ts", ev_t, 32'h30); chk("t2_code", ev_c, 2'b01);
        good(b_prev); rdy = 1'b1; step(); rdy = 1'b0;
        chk("t2_popped", ev_v, 0);

        // ---- overflow: 6 mismatches into a 4-deep FIFO ----
        stop = 1'b1; good(b_prev); step(); stop = 1'b0;
        chk("t3_idle", st, 0);
        start = 1'b1; step(); start = 1'b0; step();
        chk("t3_run", st, 2); chk("t3_err_clr", err, 0); chk("t3_fault_clr", flt, 0);
        for (int k = 0; k < 6; k++) begin
            cq[k] = 2'(k % 3 + 1);
            tq[k] = exp_ts;
            bad(cq[k]); step();
        end
        chk("t3_err", err, 6); chk("t3_drop", ev_d, 1); chk("t3_valid", ev_v, 1);
        chk("t3_head_ts", ev_t, tq[0]); chk("t3_head_code", ev_c, cq[0]);
        good(b_prev); step();
        chk("t3_hold_ts", ev_t, tq[0]);
        rdy = 1'b1; cq[6] = 2'b10; tq[6] = exp_ts; bad(cq[6]); step();
        chk("t3_fullpop_err", err, 7);
        chk("t3_q1_ts", ev_t, tq[1]); chk("t3_q1_code", ev_c, cq[1]);
        ord[0] = 2; ord[1] = 3; ord[2] = 6;
        for (int j = 0; j < 3; j++) begin
            good(b_prev); step();
            chk("t3_q_ts", ev_t, tq[ord[j]]); chk("t3_q_code", ev_c, cq[ord[j]]);
        end
        good(b_prev); step(); rdy = 1'b0;
        chk("t3_drained", ev_v, 0); chk("t3_drop_sticky", ev_d, 1);

        // ---- start/stop collisions ----
        stop = 1'b1; step(); stop = 1'b0;
        chk("t5_idle", st, 0);
        start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
        chk("t5_both_idle", st, 0); chk("t5_both_noclr", err, 7);
        start = 1'b1; good(b_prev); step(); start = 1'b0;
        chk("t5_arm", st, 1); chk("t5_err_clr", err, 0);
        step();
        chk("t5_run", st, 2);
        stop = 1'b1; t5 = exp_ts; bad(2'b01); step(); stop = 1'b0; good(b_prev);
        chk("t5_stop_idle", st, 0); chk("t5_stop_err", err, 1);
        chk("t5_stop_valid", ev_v, 1); chk("t5_stop_ts", ev_t, t5); chk("t5_stop_code", ev_c, 2'b01);

        // ---- STOP_ON_ERR instance ----
        start = 1'b1; step(); start = 1'b0; step();
        chk("t4_run", st_s, 2);
        t4 = exp_ts; bad(2'b11); step();
        chk("t4_fault_state", st_s, 3); chk("t4_err", err_s, 1); chk("t4_fault", flt_s, 1);
        chk("t4_valid", v_s, 1); chk("t4_ts", t_s, t4[3:0]); chk("t4_code", c_s, 2'b11);
        bad(2'b11); step();
        chk("t4_no_count", err_s, 1); chk("t4_still_fault", st_s, 3);
        stop = 1'b1; good(b_prev); step(); stop = 1'b0;
        chk("t4_stop_idle", st_s, 0);
        start = 1'b1; step(); start = 1'b0;
        chk("t4_rearm", st_s, 1); chk("t4_fault_clr", flt_s, 0);
        chk("t4_err_clr", err_s, 0); chk("t4_flushed", v_s, 0);

        // ---- saturation and timestamp wrap on the narrow instance ----
        step();
        n = 0;
        while (exp_ts[3:0] != 4'd14 && n < 40) begin good(b_prev); step(); n++; end
        chk("t6_reach_ts", exp_ts[3:0], 14);
        for (int k = 0; k < 9; k++) begin bad(2'b01); step(); end
        chk("t6_sat", err_w, 7); chk("t6_w_drop", d_w, 1); chk("t6_w_head", t_w, 14);
        chk("t6_main_err", err, 9); chk("t6_main_drop", ev_d, 1);
        rdy_w = 1'b1; good(b_prev); step();
        chk("t6_w_15", t_w, 15);
        step();
        chk("t6_w_wrap", t_w, 0);
        rdy_w = 1'b0;

        // ---- reset mid-operation ----
        chk("t6_pre_valid", ev_v, 1);
        reset = 1'b1; good(1'b0); step(); reset = 1'b0;
        chk("r_state", st, 0);  chk("r_tog", tog, 0);    chk("r_err", err, 0);
        chk("r_fault", flt, 0); chk("r_valid", ev_v, 0); chk("r_ts", ev_t, 0);
        chk("r_code", ev_c, 0); chk("r_drop", ev_d, 0);
        chk("r_s_state", st_s, 0); chk("r_s_tog", tog_s, 0); chk("r_s_drop", d_s, 0);
        chk("r_w_valid", v_w, 0);  chk("r_w_err", err_w, 0); chk("r_w_tog", tog_w, 0);
        chk("r_w_fault", flt_w, 0); chk("r_w_code", c_w, 0); chk("r_w_state", st_w, 0);
        start = 1'b1; step(); start = 1'b0; step();
        t6 = exp_ts; bad(2'b10); step();
        chk("r_after_ts", ev_t, t6); chk("r_after_code", ev_c, 2'b10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
